gate_pair_apply_seq: RTL and testbench

Sequencer that applies one 2x2 complex gate matrix to an amplitude pair (a0, a1), producing out0 = g00*a0 + g01*a1 and out1 = g10*a0 + g11*a1.
Time-multiplexes a single complex_fix_mul instance over four products, accumulating in registers.
Sits between the state-vector amplitude fetch logic and the write-back stage.
Valid/ready handshakes on both input and output sides.

---
 rtl/gate_pkg.sv | 69 ++++++
 rtl/complex_fix_mul.sv | 41 ++++
 rtl/cplx_acc_add.sv | 46 ++++
 rtl/gate_pair_apply_seq.sv | 167 ++++++++++++++++
 tb/tb_gate_pair_apply_seq.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared definitions for the gate-pair sequencer: component and
//               gate-entry indices, sequencer state encoding, and the
//               sign-extended add with saturating or wrapping reduction.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

  // Component index inside a complex value
  localparam int REAL = 0;
  localparam int IMAG = 1;

  // Gate matrix entry index
  localparam int G00 = 0;
  localparam int G01 = 1;
  localparam int G10 = 2;
  localparam int G11 = 3;

  // Working width for the reduction helpers; callers sign-extend into it
  localparam int c_ext_w = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    OUT  = 3'd5
  } state_t;

  // Sum of two sign-extended operands, reduced to a w-bit range. With sat_en
  // the result clamps to the w-bit limits; otherwise the full sum is returned
  // and the caller keeps its low w bits (two's-complement wrap).
  function automatic logic signed [c_ext_w-1:0] add_red(
    input logic signed [c_ext_w-1:0] a,
    input logic signed [c_ext_w-1:0] b,
    input int                        w,
    input bit                        sat_en
  );
    logic signed [c_ext_w-1:0] s;
    logic signed [c_ext_w-1:0] hi;
    logic signed [c_ext_w-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sat_en && (s > hi)) return hi;
    if (sat_en && (s < lo)) return lo;
    return s;
  endfunction

  // True when the sum of two sign-extended operands leaves the w-bit range.
  function automatic logic add_ovf(
    input logic signed [c_ext_w-1:0] a,
    input logic signed [c_ext_w-1:0] b,
    input int                        w
  );
    logic signed [c_ext_w-1:0] s;
    logic signed [c_ext_w-1:0] hi;
    logic signed [c_ext_w-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

endpackage
`default_nettype wire

// File: rtl/complex_fix_mul.sv
`default_nettype none
// ============================================================================
// Module      : complex_fix_mul
// Description : Combinational fixed-point complex multiply p = a * b.
//               Full-precision products are formed, scaled right by
//               2*IN_BITS-OUT_BITS-1 (floor) and the low OUT_BITS kept.
// Ports       : a, b - complex operands, IN_BITS per component
//               p    - complex product, OUT_BITS per component
// Revision    : 1.0 - initial release
// ============================================================================
module complex_fix_mul
  import gate_pkg::*;
#(
  parameter int IN_BITS  = 19,
  parameter int OUT_BITS = 20
) (
  input  logic signed [0:1][IN_BITS-1:0]  a,
  input  logic signed [0:1][IN_BITS-1:0]  b,
  output logic signed [0:1][OUT_BITS-1:0] p
);

  localparam int c_prod_w = 2 * IN_BITS + 1;
  localparam int c_shift  = 2 * IN_BITS - OUT_BITS - 1;

  logic signed [c_prod_w-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [c_prod_w-1:0] w_re_full, w_im_full;

  assign w_ar = c_prod_w'($signed(a[REAL]));
  assign w_ai = c_prod_w'($signed(a[IMAG]));
  assign w_br = c_prod_w'($signed(b[REAL]));
  assign w_bi = c_prod_w'($signed(b[IMAG]));

  // One extra bit over the raw product width keeps the difference/sum exact
  assign w_re_full = w_ar * w_br - w_ai * w_bi;
  assign w_im_full = w_ar * w_bi + w_ai * w_br;

  assign p[REAL] = OUT_BITS'(w_re_full >>> c_shift);
  assign p[IMAG] = OUT_BITS'(w_im_full >>> c_shift);

endmodule
`default_nettype wire

// File: rtl/cplx_acc_add.sv
`default_nettype none
// ============================================================================
// Module      : cplx_acc_add
// Description : Combinational complex add, REAL and IMAG reduced independently
//               to OUT_BITS. Build macro GATE_PAIR_APPLY_SAT_EN selects
//               saturation and adds the ovf output; otherwise results wrap.
// Ports       : a, b - complex addends, OUT_BITS per component
//               sum  - reduced complex sum
//               ovf  - (GATE_PAIR_APPLY_SAT_EN only) any component clamped
// Revision    : 1.0 - initial release
// ============================================================================
module cplx_acc_add
  import gate_pkg::*;
#(
  parameter int OUT_BITS = 20
) (
  input  logic [0:1][OUT_BITS-1:0] a,
  input  logic [0:1][OUT_BITS-1:0] b,
  output logic [0:1][OUT_BITS-1:0] sum
`ifdef GATE_PAIR_APPLY_SAT_EN
  ,
  output logic                     ovf
`endif
);

`ifdef GATE_PAIR_APPLY_SAT_EN
  localparam bit c_sat_en = 1'b1;
`else
  localparam bit c_sat_en = 1'b0;
`endif

  function automatic logic signed [c_ext_w-1:0] sx(input logic [OUT_BITS-1:0] v);
    return {{(c_ext_w - OUT_BITS){v[OUT_BITS-1]}}, v};
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_comp
    assign sum[i] = OUT_BITS'(add_red(sx(a[i]), sx(b[i]), OUT_BITS, c_sat_en));
  end

`ifdef GATE_PAIR_APPLY_SAT_EN
  assign ovf = add_ovf(sx(a[REAL]), sx(b[REAL]), OUT_BITS) |
               add_ovf(sx(a[IMAG]), sx(b[IMAG]), OUT_BITS);
`endif

endmodule
`default_nettype wire

// File: rtl/gate_pair_apply_seq.sv
`default_nettype none
// ============================================================================
// Module      : gate_pair_apply_seq
// Description : Applies a 2x2 complex gate to an amplitude pair:
//                 out0 = g00*a0 + g01*a1, out1 = g10*a0 + g11*a1
//               using one shared complex multiplier over four cycles.
// Ports       : in_valid/in_ready   - operand handshake (accepted in IDLE)
//               gate, amp0, amp1    - operands, latched on accept
//               out_valid/out_ready - result handshake
//               out0, out1          - results, stable while out_valid
//               busy                - not IDLE
//               op_count            - completed output handshakes (wraps)
//               sat_flag            - (GATE_PAIR_APPLY_SAT_EN only) a result
//                                     component saturated
// Build macro : GATE_PAIR_APPLY_SAT_EN - saturating accumulate + sat_flag
// Revision    : 1.0 - initial release
// ============================================================================
module gate_pair_apply_seq
  import gate_pkg::*;
#(
  parameter int IN_BITS  = 19,
  parameter int OUT_BITS = 20,
  parameter int CNT_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [0:3][0:1][IN_BITS-1:0] gate,
  input  logic signed [0:1][IN_BITS-1:0]    amp0,
  input  logic signed [0:1][IN_BITS-1:0]    amp1,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [0:1][OUT_BITS-1:0]   out0,
  output logic signed [0:1][OUT_BITS-1:0]   out1,
  output logic                              busy,
  output logic [CNT_BITS-1:0]               op_count
`ifdef GATE_PAIR_APPLY_SAT_EN
  ,
  output logic                              sat_flag
`endif
);

  state_t r_state, w_state_nxt;

  logic [0:3][0:1][IN_BITS-1:0] r_gate;
  logic [0:1][IN_BITS-1:0]      r_amp0, r_amp1;
  logic [0:1][OUT_BITS-1:0]     r_acc0, r_acc1;
  logic [CNT_BITS-1:0]          r_op_count;

  logic [0:1][IN_BITS-1:0]      w_mul_a, w_mul_b;
  logic [0:1][OUT_BITS-1:0]     w_prod, w_add_a, w_sum;

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = P0;
      end
      P0:  w_state_nxt = P1;
      P1:  w_state_nxt = P2;
      P2:  w_state_nxt = P3;
      P3:  w_state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiplier operands come only from the latched copies
  always_comb begin
    w_mul_a = r_gate[G00];
    w_mul_b = r_amp0;
    case (r_state)
      P1: begin w_mul_a = r_gate[G01]; w_mul_b = r_amp1; end
      P2: begin w_mul_a = r_gate[G10]; w_mul_b = r_amp0; end
      P3: begin w_mul_a = r_gate[G11]; w_mul_b = r_amp1; end
      default: ;
    endcase
  end

  // P1 accumulates into acc0, P3 into acc1
  assign w_add_a = (r_state == P3) ? r_acc1 : r_acc0;

  complex_fix_mul #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_mul (
    .a (w_mul_a),
    .b (w_mul_b),
    .p (w_prod)
  );

`ifdef GATE_PAIR_APPLY_SAT_EN
  logic w_ovf;
  logic r_sat;

  cplx_acc_add #(.OUT_BITS(OUT_BITS)) u_add (
    .a   (w_add_a),
    .b   (w_prod),
    .sum (w_sum),
    .ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        P1:      r_sat <= w_ovf;
        P3:      r_sat <= r_sat | w_ovf;
        OUT:     if (out_ready) r_sat <= 1'b0;
        default: ;
      endcase
    end
  end

  assign sat_flag = r_sat & (r_state == OUT);
`else
  cplx_acc_add #(.OUT_BITS(OUT_BITS)) u_add (
    .a   (w_add_a),
    .b   (w_prod),
    .sum (w_sum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gate     <= '0;
      r_amp0     <= '0;
      r_amp1     <= '0;
      r_acc0     <= '0;
      r_acc1     <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (in_valid) begin
          r_gate <= gate;
          r_amp0 <= amp0;
          r_amp1 <= amp1;
        end
        P0:  r_acc0 <= w_prod;
        P1:  r_acc0 <= w_sum;
        P2:  r_acc1 <= w_prod;
        P3:  r_acc1 <= w_sum;
        OUT: if (out_ready) r_op_count <= r_op_count + CNT_BITS'(1);
        default: ;
      endcase
    end
  end

  assign out0     = r_acc0;
  assign out1     = r_acc1;
  assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_gate_pair_apply_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_pair_apply_seq
// Description : Self-checking bench for gate_pair_apply_seq. A scoreboard
//               captures operands at each accepted handshake, computes the
//               expected results from the gate-apply arithmetic, and checks
//               every valid output cycle; directed literals pin known cases.
//               The counter is narrowed to 8 bits so its wrap is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_pair_apply_seq;

  localparam int IN_BITS  = 19;
  localparam int OUT_BITS = 20;
  localparam int CNT_BITS = 8;
`ifdef GATE_PAIR_APPLY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic signed [0:3][0:1][IN_BITS-1:0] gate_t;
  typedef logic signed [0:1][IN_BITS-1:0]      amp_t;
  typedef struct { longint o0r; longint o0i; longint o1r; longint o1i; bit sat; } exp_t;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              in_valid, in_ready;
  gate_t                             gate;
  amp_t                              amp0, amp1;
  logic                              out_valid, out_ready;
  logic signed [0:1][OUT_BITS-1:0]   out0, out1;
  logic                              busy;
  logic [CNT_BITS-1:0]               op_count;
  logic                              sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t   q[$];
  longint model_cnt = 0;
  int     hs = 0;
  int     lat = 0;
  bit     waiting = 0;

  always #5 clk = ~clk;

  gate_pair_apply_seq #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gate      (gate),
    .amp0      (amp0),
    .amp1      (amp1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .busy      (busy),
    .op_count  (op_count)
`ifdef GATE_PAIR_APPLY_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

`ifndef GATE_PAIR_APPLY_SAT_EN
  assign sat_flag = 1'b0;
`endif

  // ---------------------------------------------------------------- model
  function automatic longint svi(input logic [IN_BITS-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint svo(input logic [OUT_BITS-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrapw(input longint x);
    longint span = longint'(1) <<< OUT_BITS;
    longint half = span / 2;
    longint r    = (x + half) % span;
    if (r < 0) r += span;
    return r - half;
  endfunction

  // Exact complex product, scaled by 2^-(2*IN_BITS-OUT_BITS-1), wrapped
  function automatic void cmul(input longint ar, input longint ai,
                               input longint br, input longint bi,
                               output longint pr, output longint pi);
    pr = wrapw((ar * br - ai * bi) >>> (2 * IN_BITS - OUT_BITS - 1));
    pi = wrapw((ar * bi + ai * br) >>> (2 * IN_BITS - OUT_BITS - 1));
  endfunction

  function automatic longint addr(input longint x, input longint y, inout bit s);
    longint t  = x + y;
    longint hi = (longint'(1) <<< (OUT_BITS - 1)) - 1;
    longint lo = -(hi + 1);
    if (SAT) begin
      if (t > hi) begin s = 1'b1; return hi; end
      if (t < lo) begin s = 1'b1; return lo; end
      return t;
    end
    return wrapw(t);
  endfunction

  function automatic exp_t model(input gate_t g, input amp_t x0, input amp_t x1);
    exp_t e;
    bit s;
    longint r00, i00, r01, i01, r10, i10, r11, i11;
    s = 1'b0;
    cmul(svi(g[0][0]), svi(g[0][1]), svi(x0[0]), svi(x0[1]), r00, i00);
    cmul(svi(g[1][0]), svi(g[1][1]), svi(x1[0]), svi(x1[1]), r01, i01);
    cmul(svi(g[2][0]), svi(g[2][1]), svi(x0[0]), svi(x0[1]), r10, i10);
    cmul(svi(g[3][0]), svi(g[3][1]), svi(x1[0]), svi(x1[1]), r11, i11);
    e.o0r = addr(r00, r01, s);
    e.o0i = addr(i00, i01, s);
    e.o1r = addr(r10, r11, s);
    e.o1i = addr(i10, i11, s);
    e.sat = s;
    return e;
  endfunction

  function automatic amp_t mk(input longint re, input longint im);
    amp_t v;
    v[0] = IN_BITS'(re);
    v[1] = IN_BITS'(im);
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_op_count", op_count, 0);
      check("rst_out0_re", svo(out0[0]), 0);
      check("rst_out0_im", svo(out0[1]), 0);
      check("rst_out1_re", svo(out1[0]), 0);
      check("rst_out1_im", svo(out1[1]), 0);
      check("rst_sat_flag", sat_flag, 0);
      q.delete();
      model_cnt = 0;
      hs        = 0;
      waiting   = 1'b0;
    end else begin
      if (waiting) begin
        lat++;
        if (out_valid) begin
          check("latency", lat, 5);
          waiting = 1'b0;
        end
      end
      check("op_count", op_count, model_cnt % (longint'(1) <<< CNT_BITS));
      check("busy_vs_in_ready", busy, !in_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
        end else begin
          check("out0_re", svo(out0[0]), q[0].o0r);
          check("out0_im", svo(out0[1]), q[0].o0i);
          check("out1_re", svo(out1[0]), q[0].o1r);
          check("out1_im", svo(out1[1]), q[0].o1i);
          check("in_ready_in_out", in_ready, 0);
          if (SAT) check("sat_flag", sat_flag, q[0].sat);
          if (out_ready) begin
            void'(q.pop_front());
            model_cnt++;
            hs++;
          end
        end
      end else begin
        check("sat_flag_idle", sat_flag, 0);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(gate, amp0, amp1));
        waiting = 1'b1;
        lat     = 0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Called at posedge+#1. Returns two cycles after the accept edge (in P2),
  // having driven junk with in_valid high while the block was busy.
  task automatic send(input gate_t g, input amp_t x0, input amp_t x1);
    int n;
    gate = g; amp0 = x0; amp1 = x1; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      gate = gate_t'({$urandom, $urandom, $urandom});
      amp0 = amp_t'($urandom);
      amp1 = amp_t'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < max) begin n++; @(negedge clk); end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  gate_t g_diag, g_full;
  amp_t  a0_diag, a1_diag, a_full;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    gate = '0; amp0 = '0; amp1 = '0;
    g_diag[0] = mk(1000, -2000);
    g_diag[1] = mk(0, 0);
    g_diag[2] = mk(0, 0);
    g_diag[3] = mk(1000, -2000);
    a0_diag   = mk(3000, 500);
    a1_diag   = mk(-700, 1200);
    a_full    = mk((1 << (IN_BITS - 1)) - 1, 0);
    for (int i = 0; i < 4; i++) g_full[i] = a_full;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Diagonal gate with 10 cycles of backpressure
    send(g_diag, a0_diag, a1_diag);
    wait_out(20);
    check("diag_out0_re", svo(out0[0]), 30);
    check("diag_out0_im", svo(out0[1]), -42);
    check("diag_out1_re", svo(out1[0]), 12);
    check("diag_out1_im", svo(out1[1]), 19);
    repeat (10) @(posedge clk);
    #1;
    check("bp_out0_re_held", svo(out0[0]), 30);
    check("bp_op_count", op_count, 0);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("hs_op_count", op_count, 1);
    check("hs_in_ready", in_ready, 1);
    check("hs_out_valid", out_valid, 0);

    // Full-scale operands: the accumulate overflows
    @(posedge clk); #1 out_ready = 1'b1;
    send(g_full, a_full, a_full);
    wait_out(20);
    if (SAT) begin
      check("ovf_out0_re_sat", svo(out0[0]), 524287);
      check("ovf_sat_flag", sat_flag, 1);
    end else begin
      check("ovf_out0_re_wrap", svo(out0[0]), -8);
    end
    check("ovf_out0_im", svo(out0[1]), 0);

    // Reset while in P2; the in-flight op is dropped
    @(posedge clk); #1 out_ready = 1'b0;
    send(g_diag, a0_diag, a1_diag);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_op_count", op_count, 0);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    send(g_diag, a1_diag, a0_diag);
    wait_out(20);
    check("post_rst_out0_re", svo(out0[0]), 12);
    check("post_rst_out1_im", svo(out1[1]), -42);

    // Counter wrap: back-to-back ops with operands changing every cycle
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 3000 && hs < (1 << CNT_BITS); c++) begin
      gate = gate_t'({$urandom, $urandom, $urandom});
      amp0 = amp_t'($urandom);
      amp1 = amp_t'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("wrap_handshakes", hs, 1 << CNT_BITS);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("wrap_op_count", op_count, 0);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
